// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM below MMIO_BASE, MMIO registers above, one-cycle read latency.
// Optional cycle counter at MMIO offset 0x2 is built only when DMEM_CYCLE_CTR_EN is defined.
module dmem_responder #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hFF0,
  parameter int                MMIO_SIZE = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] led_out,
  output logic [DATA_W-1:0] wr_count
);

  localparam int RAM_WORDS = int'(MMIO_BASE);
  localparam logic [ADDR_W-1:0] OFF_LED   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_WRCNT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_CYCLE = ADDR_W'(2);

  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [DATA_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] off;
  logic              in_ram, in_mmio, ram_we;

  assign in_ram  = address < MMIO_BASE;
  assign in_mmio = !in_ram && (int'(address) < int'(MMIO_BASE) + MMIO_SIZE);
  assign off     = address - MMIO_BASE;
  assign ram_we  = wren && in_ram;

`ifdef DMEM_CYCLE_CTR_EN
  logic [DATA_W-1:0] cyc_q, cyc_d;

  // A software clear wins over the free-running increment.
  always_comb begin
    cyc_d = cyc_q + DATA_W'(1);
    if (wren && in_mmio && off == OFF_CYCLE) cyc_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end
`endif

  always_comb begin
    q_d = '0;
    if (in_ram) begin
      q_d = mem[address];
    end else if (in_mmio) begin
      case (off)
        OFF_LED:   q_d = led_q;
        OFF_WRCNT: q_d = wr_cnt_q;
`ifdef DMEM_CYCLE_CTR_EN
        OFF_CYCLE: q_d = cyc_q;
`endif
        default:   q_d = '0;
      endcase
    end
  end

  always_comb begin
    led_d    = led_q;
    wr_cnt_d = wr_cnt_q;
    if (wren && in_mmio && off == OFF_LED) led_d = data;
    if (ram_we && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + DATA_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q      <= '0;
      led_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      q_q      <= q_d;
      led_q    <= led_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // RAM contents survive reset; only the write is suppressed.
  always_ff @(posedge clock) begin
    if (!reset && ram_we) mem[address] <= data;
  end

  assign q        = q_q;
  assign led_out  = led_q;
  assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; cycle-counter expectations follow DMEM_CYCLE_CTR_EN.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q, led_out, wr_count;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef DMEM_CYCLE_CTR_EN
  localparam bit CTR_EN = 1'b1;
`else
  localparam bit CTR_EN = 1'b0;
`endif

  dmem_responder dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .q        (q),
    .led_out  (led_out),
    .wr_count (wr_count)
  );

  always #5 clock = ~clock;

  task automatic step(input logic rst, input logic [11:0] a, input logic [31:0] d, input logic we);
    reset   = rst;
    address = a;
    data    = d;
    wren    = we;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; address = '0; data = '0; wren = 1'b0;
    #2;

    step(1'b1, 12'h005, 32'hCAFE0000, 1'b1);
    check("rst_q", q, 32'h0);
    check("rst_led", led_out, 32'h0);
    check("rst_wrcnt", wr_count, 32'h0);

    // RAM write and readback
    step(1'b0, 12'h005, 32'hDEADBEEF, 1'b1);
    check("wr1_cnt", wr_count, 32'd1);
    step(1'b0, 12'h005, 32'h0, 1'b0);
    check("rd005", q, 32'hDEADBEEF);

    // read-before-write at same address
    step(1'b0, 12'h010, 32'h11111111, 1'b1);
    step(1'b0, 12'h010, 32'h22222222, 1'b1);
    check("rbw_old", q, 32'h11111111);
    check("rbw_cnt", wr_count, 32'd3);
    step(1'b0, 12'h010, 32'h0, 1'b0);
    check("rbw_new", q, 32'h22222222);

    // MMIO LED, read-only WR_COUNT, reserved slot
    step(1'b0, 12'hFF0, 32'h000000A5, 1'b1);
    check("led_set", led_out, 32'h000000A5);
    check("led_q_pre", q, 32'h0);
    check("led_cnt", wr_count, 32'd3);
    step(1'b0, 12'hFF1, 32'h12345678, 1'b1);
    check("ro_q", q, 32'd3);
    check("ro_cnt", wr_count, 32'd3);
    step(1'b0, 12'hFF0, 32'h0, 1'b0);
    check("led_rd", q, 32'h000000A5);
    step(1'b0, 12'hFF5, 32'hFFFFFFFF, 1'b1);
    step(1'b0, 12'hFF5, 32'h0, 1'b0);
    check("rsvd_rd", q, 32'h0);
    check("rsvd_cnt", wr_count, 32'd3);

    // reset mid-operation drops the concurrent write
    step(1'b0, 12'h020, 32'h00000077, 1'b1);
    check("pre_rst_cnt", wr_count, 32'd4);
    step(1'b1, 12'h020, 32'h00000055, 1'b1);
    check("mid_rst_led", led_out, 32'h0);
    check("mid_rst_cnt", wr_count, 32'h0);
    check("mid_rst_q", q, 32'h0);
    step(1'b0, 12'h020, 32'h0, 1'b0);
    check("rst_drop_wr", q, 32'h00000077);
    check("rst_drop_cnt", wr_count, 32'h0);

    // cycle counter: 10 idle edges after reset, then read
    step(1'b1, 12'h000, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 12'h000, 32'h0, 1'b0);
    step(1'b0, 12'hFF2, 32'h0, 1'b0);
    check("cyc10", q, CTR_EN ? 32'd10 : 32'd0);
    step(1'b0, 12'hFF2, 32'hABCD, 1'b1);
    check("cyc_wr_pre", q, CTR_EN ? 32'd11 : 32'd0);
    check("cyc_wr_cnt", wr_count, 32'h0);
    step(1'b0, 12'h000, 32'h0, 1'b0);
    step(1'b0, 12'hFF2, 32'h0, 1'b0);
    check("cyc_clr", q, CTR_EN ? 32'd1 : 32'd0);

    // wr_count saturation
    @(negedge clock);
    force dut.wr_cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.wr_cnt_q;
    check("sat_force", wr_count, 32'hFFFFFFFE);
    step(1'b0, 12'h030, 32'h1, 1'b1);
    check("sat_1", wr_count, 32'hFFFFFFFF);
    step(1'b0, 12'h031, 32'h2, 1'b1);
    check("sat_2", wr_count, 32'hFFFFFFFF);
    step(1'b0, 12'h031, 32'h0, 1'b0);
    check("sat_rd", q, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
